rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_if.sv | 31 +++
 rtl/rom_arbiter.sv | 110 +++++++++++
 tb/tb_rom_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// Bus bundle for the two-requester ROM arbiter. It carries the request/ack
// channels for A and B, the ROM address/enable/data lines, and busy.
interface rom_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic          a_ack;
    logic [DW-1:0] a_data;
    logic          b_req;
    logic [AW-1:0] b_addr;
    logic          b_ack;
    logic [DW-1:0] b_data;
    logic          rom_ce;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;

    // Arbiter side
    modport slave (
        input  a_req, a_addr, b_req, b_addr, rom_data,
        output a_ack, a_data, b_ack, b_data, rom_ce, rom_addr, busy
    );

    // Requester / ROM side
    modport master (
        output a_req, a_addr, b_req, b_addr, rom_data,
        input  a_ack, a_data, b_ack, b_data, rom_ce, rom_addr, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter that shares one 1-cycle synchronous ROM between two
// requesters. Each access takes IDLE (grant) -> ISSUE -> CAPT, and the
// owner's ack pulses in the cycle after CAPT, which is the next IDLE cycle.
module rom_arbiter #(
    parameter int DW = 8,
    parameter int AW = 14
) (
    input  logic          clock,
    input  logic          reset,
    rom_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_elig_a;
    logic          w_elig_b;
    logic          w_grant_a;
    logic          w_grant_b;
    logic          r_owner_b;
    logic          r_last_b;
    logic          r_a_ack;
    logic          r_b_ack;
    logic          r_rom_ce;
    logic [AW-1:0] r_rom_addr;
    logic [DW-1:0] r_a_data;
    logic [DW-1:0] r_b_data;

    // A port whose ack is showing this cycle is not eligible for a grant.
    assign w_elig_a = bus.a_req & ~r_a_ack;
    assign w_elig_b = bus.b_req & ~r_b_ack;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and grant selection
    always_comb begin
        w_next    = r_state;
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig_a && w_elig_b) begin
                    w_grant_a = r_last_b;
                    w_grant_b = ~r_last_b;
                end else begin
                    w_grant_a = w_elig_a;
                    w_grant_b = w_elig_b;
                end
                if (w_grant_a || w_grant_b) w_next = ISSUE;
            end
            ISSUE:   w_next = CAPT;
            CAPT:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: address capture at grant, data capture and ack in CAPT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rom_ce   <= 1'b0;
            r_rom_addr <= '0;
            r_owner_b  <= 1'b0;
            r_last_b   <= 1'b1;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_a_data   <= '0;
            r_b_data   <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_a || w_grant_b) begin
                        r_rom_addr <= w_grant_b ? bus.b_addr : bus.a_addr;
                        r_rom_ce   <= 1'b1;
                        r_owner_b  <= w_grant_b;
                    end else begin
                        r_rom_ce   <= 1'b0;
                    end
                end
                CAPT: begin
                    r_rom_ce <= 1'b0;
                    r_last_b <= r_owner_b;
                    if (r_owner_b) begin
                        r_b_data <= bus.rom_data;
                        r_b_ack  <= 1'b1;
                    end else begin
                        r_a_data <= bus.rom_data;
                        r_a_ack  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.a_ack    = r_a_ack;
    assign bus.b_ack    = r_b_ack;
    assign bus.a_data   = r_a_data;
    assign bus.b_data   = r_b_data;
    assign bus.rom_ce   = r_rom_ce;
    assign bus.rom_addr = r_rom_addr;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter. The ROM model returns addr[7:0] ^ 8'hC3.
// Expected ROM words are written below as hand-computed constants.
module tb_rom_arbiter;

    localparam int DW = 8;
    localparam int AW = 14;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rom_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    rom_arbiter #(.DW(DW), .AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // 1-cycle synchronous ROM
    always @(posedge clock) begin
        if (bus.rom_ce) bus.rom_data <= bus.rom_addr[7:0] ^ 8'hC3;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.a_req  = 1'b0;
        bus.b_req  = 1'b0;
        bus.a_addr = '0;
        bus.b_addr = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_ce", bus.rom_ce, 0);
        chk("rst_addr", bus.rom_addr, 0);
        chk("rst_aack", bus.a_ack, 0);
        chk("rst_back", bus.b_ack, 0);
        chk("rst_adata", bus.a_data, 0);
        chk("rst_bdata", bus.b_data, 0);

        // A only, address 0x10, request dropped after the ack
        reset = 1'b0;
        bus.a_addr = 14'h0010;
        bus.a_req  = 1'b1;
        chk("a1_c0_busy", bus.busy, 0);
        tick();
        chk("a1_c1_addr", bus.rom_addr, 14'h0010);
        chk("a1_c1_ce", bus.rom_ce, 1);
        chk("a1_c1_busy", bus.busy, 1);
        chk("a1_c1_ack", bus.a_ack, 0);
        tick();
        chk("a1_c2_ack", bus.a_ack, 0);
        chk("a1_c2_busy", bus.busy, 1);
        tick();
        chk("a1_c3_ack", bus.a_ack, 1);
        chk("a1_c3_data", bus.a_data, 8'hD3);
        chk("a1_c3_back", bus.b_ack, 0);
        chk("a1_c3_busy", bus.busy, 0);
        chk("a1_c3_ce", bus.rom_ce, 0);
        tick();
        chk("a1_c4_ack", bus.a_ack, 0);
        bus.a_req = 1'b0;
        tick();
        tick();
        chk("a1_idle_busy", bus.busy, 0);
        chk("a1_idle_ack", bus.a_ack, 0);
        chk("a1_idle_data", bus.a_data, 8'hD3);

        // A held high: the ack cycle is ineligible, regrant one cycle later
        bus.a_addr = 14'h0011;
        bus.a_req  = 1'b1;
        tick();
        tick();
        tick();
        chk("a2_c3_ack", bus.a_ack, 1);
        chk("a2_c3_data", bus.a_data, 8'hD2);
        tick();
        bus.a_addr = 14'h0012;
        chk("a2_c4_busy", bus.busy, 0);
        chk("a2_c4_ack", bus.a_ack, 0);
        tick();
        chk("a2_c5_busy", bus.busy, 1);
        chk("a2_c5_addr", bus.rom_addr, 14'h0012);
        tick();
        chk("a2_c6_ack", bus.a_ack, 0);
        tick();
        chk("a2_c7_ack", bus.a_ack, 1);
        chk("a2_c7_data", bus.a_data, 8'hD1);
        bus.a_req = 1'b0;
        tick();
        tick();
        chk("a2_idle_busy", bus.busy, 0);

        // Reset, then both request continuously for 12 cycles
        reset = 1'b1;
        tick();
        chk("r2_adata", bus.a_data, 0);
        reset = 1'b0;
        bus.a_addr = 14'h0001;
        bus.b_addr = 14'h0002;
        bus.a_req  = 1'b1;
        bus.b_req  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 4) bus.a_addr = 14'h0003;
            if (c == 7) bus.b_addr = 14'h0004;
            chk($sformatf("rr_c%0d_aack", c), bus.a_ack, (c == 3 || c == 9));
            chk($sformatf("rr_c%0d_back", c), bus.b_ack, (c == 6 || c == 12));
            if (c == 3)  chk("rr_c3_adata", bus.a_data, 8'hC2);
            if (c == 6)  chk("rr_c6_bdata", bus.b_data, 8'hC1);
            if (c == 9)  chk("rr_c9_adata", bus.a_data, 8'hC0);
            if (c == 12) chk("rr_c12_bdata", bus.b_data, 8'hC7);
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
        tick();
        chk("rr_idle_busy", bus.busy, 0);

        // B only; b_addr changes in the cycle after grant
        bus.b_addr = 14'h0020;
        bus.b_req  = 1'b1;
        tick();
        chk("b_c1_addr", bus.rom_addr, 14'h0020);
        bus.b_addr = 14'h0030;
        tick();
        chk("b_c2_addr", bus.rom_addr, 14'h0020);
        tick();
        chk("b_c3_ack", bus.b_ack, 1);
        chk("b_c3_data", bus.b_data, 8'hE3);
        chk("b_c3_aack", bus.a_ack, 0);
        chk("b_c3_adata", bus.a_data, 8'hC0);
        bus.b_req = 1'b0;
        tick();
        tick();
        chk("b_idle_busy", bus.busy, 0);

        // Reset during ISSUE of an A access
        bus.a_addr = 14'h0005;
        bus.a_req  = 1'b1;
        tick();
        chk("ri_c1_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("ri_busy", bus.busy, 0);
        chk("ri_ce", bus.rom_ce, 0);
        chk("ri_addr", bus.rom_addr, 0);
        chk("ri_adata", bus.a_data, 0);
        chk("ri_bdata", bus.b_data, 0);
        tick();
        chk("ri_held_ack", bus.a_ack, 0);
        reset = 1'b0;
        tick();
        chk("ri_r1_ack", bus.a_ack, 0);
        chk("ri_r1_busy", bus.busy, 1);
        tick();
        chk("ri_r2_ack", bus.a_ack, 0);
        tick();
        chk("ri_r3_ack", bus.a_ack, 1);
        chk("ri_r3_data", bus.a_data, 8'hC6);
        bus.a_req = 1'b0;
        tick();
        chk("ri_r4_ack", bus.a_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
